// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM/WB slice: widths, memory-stage FSM states
// and the control bits that travel into write-back.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Single-port word memory: write lands on the clock edge, read is combinational
// so a load sees the contents as they were before a same-cycle store.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage with wait-stated data memory, stall generation, MEM/WB
// pipeline register and the final write-back mux.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W    = pipe_pkg::DATA_W,
  parameter int REG_AW    = pipe_pkg::REG_AW,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALUresEX,
  input  logic [DATA_W-1:0] StoreDataEX,
  input  logic [REG_AW-1:0] EX_MEMRd,
  input  logic              MemReadEX,
  input  logic              MemWriteEX,
  input  logic              MemtoRegEX,
  input  logic              RegWriteEX,
  output logic              mem_stall,
  output logic [DATA_W-1:0] ReadDataWB,
  output logic [DATA_W-1:0] ALUresWB,
  output logic [REG_AW-1:0] MEM_WBRd,
  output logic              MemtoRegWB,
  output logic              RegWriteWB,
  output logic [DATA_W-1:0] WBData,
  output logic              misalign_err
);

  localparam int AW    = $clog2(MEM_DEPTH);
  // Counter only ever holds MEM_WAIT-1 down to 0.
  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              access;
  logic              stall;
  logic              complete;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] rdata;
  wb_ctrl_t          ctrl_wb;
  logic              unused_addr_hi;

  assign access = MemReadEX | MemWriteEX;
  // Upper address bits wrap; low two bits are dropped (misalignment only flags).
  assign addr   = ALUresEX[AW+1:2];
  assign unused_addr_hi = ^{ALUresEX[DATA_W-1:AW+2], ALUresEX[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (access && (MEM_WAIT != 0)) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        stall    = access && (MEM_WAIT != 0);
        complete = access && (MEM_WAIT == 0);
      end
      BUSY: begin
        stall    = (cnt != '0);
        complete = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Reset wins over an in-flight access: no write, stall dropped.
  assign mem_stall = stall & ~rst;
  assign we        = complete & MemWriteEX & ~rst;

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (StoreDataEX),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || stall) begin
      ReadDataWB <= '0;
      ALUresWB   <= '0;
      MEM_WBRd   <= '0;
      ctrl_wb    <= '0;
    end else begin
      ReadDataWB <= MemReadEX ? rdata : '0;
      ALUresWB   <= ALUresEX;
      MEM_WBRd   <= EX_MEMRd;
      ctrl_wb    <= '{mem_to_reg: MemtoRegEX, reg_write: RegWriteEX};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               misalign_err <= 1'b0;
    else if (access && ALUresEX[1:0] != 0) misalign_err <= 1'b1;
  end

  assign MemtoRegWB = ctrl_wb.mem_to_reg;
  assign RegWriteWB = ctrl_wb.reg_write;
  assign WBData     = MemtoRegWB ? ReadDataWB : ALUresWB;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (MEM_WAIT 0/2/3) share data inputs and
// have private read/write strobes; an occupancy-based model checks every cycle.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, sd;
  logic [3:0]  rd;
  logic        m2r, rw;
  logic [2:0]  mr, mw;

  logic        stall [3];
  logic [31:0] rdwb  [3];
  logic [31:0] aluwb [3];
  logic [31:0] wbd   [3];
  logic [3:0]  rdw   [3];
  logic        m2rw  [3];
  logic        rww   [3];
  logic        mis   [3];

  always #5 clk = ~clk;

  mem_wb_stage #(.MEM_WAIT(0)) u0 (
    .clk(clk), .rst(rst), .ALUresEX(alu), .StoreDataEX(sd), .EX_MEMRd(rd),
    .MemReadEX(mr[0]), .MemWriteEX(mw[0]), .MemtoRegEX(m2r), .RegWriteEX(rw),
    .mem_stall(stall[0]), .ReadDataWB(rdwb[0]), .ALUresWB(aluwb[0]), .MEM_WBRd(rdw[0]),
    .MemtoRegWB(m2rw[0]), .RegWriteWB(rww[0]), .WBData(wbd[0]), .misalign_err(mis[0]));

  mem_wb_stage #(.MEM_WAIT(2)) u2 (
    .clk(clk), .rst(rst), .ALUresEX(alu), .StoreDataEX(sd), .EX_MEMRd(rd),
    .MemReadEX(mr[1]), .MemWriteEX(mw[1]), .MemtoRegEX(m2r), .RegWriteEX(rw),
    .mem_stall(stall[1]), .ReadDataWB(rdwb[1]), .ALUresWB(aluwb[1]), .MEM_WBRd(rdw[1]),
    .MemtoRegWB(m2rw[1]), .RegWriteWB(rww[1]), .WBData(wbd[1]), .misalign_err(mis[1]));

  mem_wb_stage #(.MEM_WAIT(3)) u3 (
    .clk(clk), .rst(rst), .ALUresEX(alu), .StoreDataEX(sd), .EX_MEMRd(rd),
    .MemReadEX(mr[2]), .MemWriteEX(mw[2]), .MemtoRegEX(m2r), .RegWriteEX(rw),
    .mem_stall(stall[2]), .ReadDataWB(rdwb[2]), .ALUresWB(aluwb[2]), .MEM_WBRd(rdw[2]),
    .MemtoRegWB(m2rw[2]), .RegWriteWB(rww[2]), .WBData(wbd[2]), .misalign_err(mis[2]));

  int vecs = 0;
  int errs = 0;
  bit started = 1'b0;

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: an access occupies W+1 cycles; the first W are bubbles with stall.
  int          W [3] = '{0, 2, 3};
  logic [31:0] mm [3][256];
  bit          kn [3][256];
  int          el [3];
  logic [31:0] e_rdwb [3], e_alu [3];
  logic [3:0]  e_rd [3];
  logic        e_m2r [3], e_rw [3], e_mis [3];
  bit          e_rdkn [3];

  always @(posedge clk) begin
    int idx;
    bit acc;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        el[k] = 0; e_rdwb[k] = 0; e_alu[k] = 0; e_rd[k] = 0;
        e_m2r[k] = 0; e_rw[k] = 0; e_mis[k] = 0; e_rdkn[k] = 1;
      end else begin
        acc = mr[k] | mw[k];
        idx = int'((alu / 4) % 256);
        if (acc && (alu % 4) != 0) e_mis[k] = 1;
        if (acc && el[k] < W[k]) begin
          el[k]++;
          e_rdwb[k] = 0; e_alu[k] = 0; e_rd[k] = 0; e_m2r[k] = 0; e_rw[k] = 0; e_rdkn[k] = 1;
        end else begin
          if (mr[k]) begin e_rdwb[k] = mm[k][idx]; e_rdkn[k] = kn[k][idx]; end
          else       begin e_rdwb[k] = 0;          e_rdkn[k] = 1;          end
          if (mw[k]) begin mm[k][idx] = sd; kn[k][idx] = 1; end
          el[k] = 0;
          e_alu[k] = alu; e_rd[k] = rd; e_m2r[k] = m2r; e_rw[k] = rw;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        cmp("stall", k, 32'(stall[k]), 32'(!rst && (mr[k] | mw[k]) && el[k] < W[k]));
        cmp("alu_wb", k, aluwb[k], e_alu[k]);
        cmp("rd_wb", k, 32'(rdw[k]), 32'(e_rd[k]));
        cmp("m2r_wb", k, 32'(m2rw[k]), 32'(e_m2r[k]));
        cmp("rw_wb", k, 32'(rww[k]), 32'(e_rw[k]));
        cmp("misalign", k, 32'(mis[k]), 32'(e_mis[k]));
        if (e_rdkn[k]) cmp("rdata_wb", k, rdwb[k], e_rdwb[k]);
        if (!e_m2r[k] || e_rdkn[k])
          cmp("wbdata", k, wbd[k], e_m2r[k] ? e_rdwb[k] : e_alu[k]);
      end
    end
  end

  task automatic idle();
    mr = '0; mw = '0; alu = '0; sd = '0; rd = '0; m2r = 1'b0; rw = 1'b0;
  endtask

  // Present one access to instance k and hold it until it completes.
  task automatic xact(input int k, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] dr, input logic mt,
                      input logic rwi, output int ns);
    logic s;
    bit done;
    alu = a; sd = d; rd = dr; m2r = mt; rw = rwi; mr[k] = r; mw[k] = w;
    ns = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      s = stall[k];
      if (s) ns++;
      @(posedge clk);
      #1;
      if (!s) done = 1'b1;
    end
    if (!done) cmp("timeout", k, 32'd0, 32'd1);
    idle();
  endtask

  // Directed literal: checks the DUT value and pins the model to the same number.
  task automatic lit(input string nm, input int k, input logic [31:0] dut_v,
                     input logic [31:0] mod_v, input logic [31:0] want);
    cmp(nm, k, dut_v, want);
    cmp({"model_", nm}, k, mod_v, want);
  endtask

  initial begin
    int ns;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      lit("rst_rw", k, 32'(rww[k]), 32'(e_rw[k]), 32'd0);
      lit("rst_alu", k, aluwb[k], e_alu[k], 32'd0);
      cmp("rst_stall", k, 32'(stall[k]), 32'd0);
    end
    rst = 1'b0;

    // Zero-wait store then load.
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'd0, 0, 0, ns);
    cmp("w0_store_stalls", 0, ns, 0);
    xact(0, 1, 0, 32'h10, 32'h0, 4'd5, 1, 1, ns);
    cmp("w0_load_stalls", 0, ns, 0);
    lit("w0_ld_data", 0, rdwb[0], e_rdwb[0], 32'hDEADBEEF);
    lit("w0_ld_rd", 0, 32'(rdw[0]), 32'(e_rd[0]), 32'd5);
    lit("w0_ld_rw", 0, 32'(rww[0]), 32'(e_rw[0]), 32'd1);
    cmp("w0_ld_wbdata", 0, wbd[0], 32'hDEADBEEF);

    // Two wait states: stall exactly twice per access.
    xact(1, 0, 1, 32'h20, 32'hCAFE0001, 4'd0, 0, 0, ns);
    cmp("w2_store_stalls", 1, ns, 2);
    xact(1, 1, 0, 32'h20, 32'h0, 4'd7, 1, 1, ns);
    cmp("w2_load_stalls", 1, ns, 2);
    lit("w2_ld_data", 1, rdwb[1], e_rdwb[1], 32'hCAFE0001);
    alu = 32'h1234; rd = 4'd3; m2r = 1'b0; rw = 1'b1;
    @(posedge clk); #1;
    idle();
    lit("w2_alu_wbdata", 1, wbd[1], e_alu[1], 32'h1234);
    cmp("w2_alu_rw", 1, 32'(rww[1]), 32'd1);

    // Address wrap and misalignment.
    xact(0, 0, 1, 32'h400, 32'hA5, 4'd0, 0, 0, ns);
    xact(0, 1, 0, 32'h003, 32'h0, 4'd1, 1, 1, ns);
    lit("wrap_data", 0, rdwb[0], e_rdwb[0], 32'hA5);
    lit("misalign_set", 0, 32'(mis[0]), 32'(e_mis[0]), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    lit("misalign_sticky", 0, 32'(mis[0]), 32'(e_mis[0]), 32'd1);

    // Read and write together: old data returned, new data stored.
    xact(0, 0, 1, 32'h8, 32'h11, 4'd0, 0, 0, ns);
    xact(0, 1, 1, 32'h8, 32'h22, 4'd2, 1, 1, ns);
    lit("rw_both_old", 0, rdwb[0], e_rdwb[0], 32'h11);
    xact(0, 1, 0, 32'h8, 32'h0, 4'd2, 1, 1, ns);
    lit("rw_both_new", 0, rdwb[0], e_rdwb[0], 32'h22);

    // Reset in the middle of a three-wait store aborts it.
    xact(2, 0, 1, 32'h30, 32'h55, 4'd0, 0, 0, ns);
    cmp("w3_store_stalls", 2, ns, 3);
    alu = 32'h30; sd = 32'h77; mw[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    cmp("abort_stall", 2, 32'(stall[2]), 32'd0);
    lit("abort_rw", 2, 32'(rww[2]), 32'(e_rw[2]), 32'd0);
    lit("abort_alu", 2, aluwb[2], e_alu[2], 32'd0);
    lit("abort_rdata", 2, rdwb[2], e_rdwb[2], 32'd0);
    cmp("abort_wbdata", 2, wbd[2], 32'd0);
    xact(2, 1, 0, 32'h30, 32'h0, 4'd4, 1, 1, ns);
    cmp("w3_load_stalls", 2, ns, 3);
    lit("abort_no_write", 2, rdwb[2], e_rdwb[2], 32'h55);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM register; ends in the MEM/WB pipeline register that feeds write-back.
- Holds a word-addressed data memory with configurable access latency (wait states).
- Raises a stall while an access is in flight and inserts write-back bubbles until the access completes.
- Also provides the final write-back data mux.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 4, destination register index width (matches EX/MEM Rd)
- MEM_DEPTH, 256, data memory depth in words (power of two)
- MEM_WAIT, 2, extra cycles per load/store; 0 = single-cycle access, no stall

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ALUresEX  in  DATA_W  byte address for loads/stores, or ALU result to pass through
- StoreDataEX  in  DATA_W  store data
- EX_MEMRd  in  REG_AW  destination register
- MemReadEX, MemWriteEX, MemtoRegEX, RegWriteEX  in  1 each  control bits from EX/MEM
- mem_stall  out  1  freeze PC/IF/ID/ID_EX/EX_MEM; upstream holds inputs stable while high
- ReadDataWB  out  DATA_W  registered load data
- ALUresWB  out  DATA_W  registered ALU result
- MEM_WBRd  out  REG_AW  registered destination register
- MemtoRegWB, RegWriteWB  out  1 each  registered control bits
- WBData  out  DATA_W  combinational: MemtoRegWB ? ReadDataWB : ALUresWB
- misalign_err  out  1  sticky; set on any access with ALUresEX[1:0] != 0

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst is synchronous and active-high.
  - On reset, all MEM/WB outputs, mem_stall and misalign_err go to 0, the FSM goes to IDLE and the wait counter to 0.
  - Memory array contents are not reset.
- Addressing:
  - Word index = ALUresEX[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored (wrap-around).
  - Misaligned address (ALUresEX[1:0] != 0): the low 2 bits are dropped, the access proceeds, and misalign_err sets and stays set until rst.
- Access = MemReadEX | MemWriteEX.
- FSM states: IDLE, BUSY.
  - IDLE, no access: MEM/WB captures the inputs every cycle. ReadDataWB captures 0.
  - IDLE, access, MEM_WAIT = 0: the access completes this cycle (see Completion). No stall.
  - IDLE, access, MEM_WAIT > 0: go to BUSY, load the wait counter with MEM_WAIT-1. mem_stall is combinationally high this same cycle. MEM/WB captures a bubble (RegWriteWB = 0, MemtoRegWB = 0; other fields don't-care, driven 0).
  - BUSY, counter > 0: decrement. mem_stall stays high. Bubble continues.
  - BUSY, counter = 0: Completion. mem_stall goes low this cycle. Return to IDLE.
- Total occupancy per access is MEM_WAIT+1 cycles; mem_stall is high for exactly MEM_WAIT cycles.
- Completion:
  - Store: the array is written exactly once, at the completion edge.
  - Load: the array is read combinationally and the result is registered into ReadDataWB.
  - ALUresWB, MEM_WBRd, MemtoRegWB and RegWriteWB capture the inputs.
- MemReadEX and MemWriteEX both set (illegal): the write is performed, and ReadDataWB returns the pre-write contents.
- Back-to-back accesses: after completion, the next access starts in the next cycle with no extra idle cycle.
- Store followed by a load to the same word: the load returns the new value.
- Reset mid-BUSY: the access is aborted, no write is performed, and mem_stall drops the following cycle.
- Latency: the MEM/WB outputs are valid one edge after completion.

Decomposition:
- Shared package pipe_pkg: DATA_W, REG_AW, state enum {IDLE, BUSY}, and a mem_wb control bundle typedef (MemtoReg, RegWrite).
- One sub-module, data_mem: single-port array with synchronous write and asynchronous read. Ports: clk, we, addr, wdata, rdata. No reset.

Test Plan:
- MEM_WAIT = 0: store 0xDEADBEEF to 0x10, then load 0x10 with Rd = 5 → next cycle ReadDataWB = 0xDEADBEEF, MEM_WBRd = 5, RegWriteWB = 1, WBData = 0xDEADBEEF. mem_stall is never high.
- MEM_WAIT = 2: load 0x20 → mem_stall high for exactly 2 cycles and RegWriteWB = 0 during them; data is registered on the 3rd edge. Non-memory ALU op with ALUresEX = 0x1234, MemtoRegEX = 0 → WBData = 0x1234 one cycle later.
- Wrap and misalignment: store 0xA5 to 0x400 with MEM_DEPTH = 256 → word 0 is written. Load from 0x003 → returns word 0 and misalign_err = 1, still 1 after 10 idle cycles.
- Read+write both set at 0x8 holding 0x11, with store data 0x22 → ReadDataWB = 0x11. A subsequent load of 0x8 returns 0x22.
- MEM_WAIT = 3, store 0x77 to 0x30, rst asserted on the 2nd BUSY cycle → all outputs 0 next cycle. A later load of 0x30 returns the old value, not 0x77.
